// File: rtl/onfi_pkg.sv
// Shared ONFI definitions: command codes, sequencer states and result-word layout.
package onfi_pkg;

    localparam logic [7:0] CMD_RESET           = 8'hFF;
    localparam logic [7:0] CMD_READ_ID         = 8'h90;
    localparam logic [7:0] CMD_READ_STATUS     = 8'h70;
    localparam logic [7:0] CMD_READ_STATUS_ENH = 8'h78;

    localparam int DATA_VALID_BIT = 8;
    localparam int DATA_TOUT_BIT  = 9;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_AD0,
        ST_AD1,
        ST_AD2,
        ST_WHR,
        ST_READ,
        ST_CAP,
        ST_TOUT,
        ST_GAP
    } state_t;

    function automatic logic [31:0] pack_result(input logic tout, input logic vld,
                                                input logic [7:0] status);
        logic [31:0] w;
        w                 = 32'h0;
        w[7:0]            = status;
        w[DATA_VALID_BIT] = vld;
        w[DATA_TOUT_BIT]  = tout;
        return w;
    endfunction

endpackage

// File: rtl/onfi_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus a one-cycle rising-edge pulse.
module onfi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/onfi_get_status.sv
// Free-running Read Status Enhanced (78h) sequencer: command, 3 row bytes, tWHR,
// DQS-strobed status capture with timeout, then CE# high for GAP cycles.
module onfi_get_status
    import onfi_pkg::*;
#(
    parameter int T_WHR   = 6,
    parameter int TIMEOUT = 64,
    parameter int GAP     = 4
) (
    input  logic        onfi_clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [7:0]  onfi_dq,
    input  logic        onfi_dqs,
    output logic [31:0] data,
    output logic        onfi_cen,
    output logic        onfi_cle,
    output logic        onfi_ale,
    output logic        onfi_wen,
    output logic [31:0] onfi_dq_o,
    output logic        onfi_dq_en,
    output logic        onfi_dqs_en
);

    // The IDLE cycle also keeps CE# high, so the GAP state itself is one cycle shorter.
    localparam int GAP_CYC = (GAP > 1) ? GAP - 1 : 1;
    localparam int WHR_CYC = (T_WHR > 0) ? T_WHR : 1;
    localparam int CNT_MAX = (TIMEOUT > WHR_CYC) ? ((TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC)
                                                 : ((WHR_CYC > GAP_CYC) ? WHR_CYC : GAP_CYC);
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t          state;
    logic            phase;
    logic [CW-1:0]   cnt;
    logic [23:0]     row;
    logic            dqs_rise;
    logic [7:0]      next_byte;
    logic            addr_unused;

    assign addr_unused = ^addr[31:24];

    onfi_sync_edge u_dqs_sync (
        .clk      (onfi_clk),
        .rst      (rst),
        .async_in (onfi_dqs),
        .rise     (dqs_rise)
    );

    always_comb begin
        next_byte = row[7:0];
        case (state)
            ST_AD0:  next_byte = row[15:8];
            ST_AD1:  next_byte = row[23:16];
            default: next_byte = row[7:0];
        endcase
    end

    always_ff @(posedge onfi_clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            phase       <= 1'b0;
            cnt         <= '0;
            row         <= '0;
            data        <= '0;
            onfi_cen    <= 1'b1;
            onfi_cle    <= 1'b0;
            onfi_ale    <= 1'b0;
            onfi_wen    <= 1'b1;
            onfi_dq_o   <= '0;
            onfi_dq_en  <= 1'b0;
            onfi_dqs_en <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    row        <= addr[23:0];
                    state      <= ST_CMD;
                    phase      <= 1'b0;
                    onfi_cen   <= 1'b0;
                    onfi_cle   <= 1'b1;
                    onfi_wen   <= 1'b0;
                    onfi_dq_en <= 1'b1;
                    onfi_dq_o  <= {24'h0, CMD_READ_STATUS_ENH};
                end
                ST_CMD, ST_AD0, ST_AD1: begin
                    if (!phase) begin
                        phase    <= 1'b1;
                        onfi_wen <= 1'b1;
                    end else begin
                        phase     <= 1'b0;
                        onfi_wen  <= 1'b0;
                        onfi_cle  <= 1'b0;
                        onfi_ale  <= 1'b1;
                        onfi_dq_o <= {24'h0, next_byte};
                        state     <= (state == ST_CMD) ? ST_AD0 :
                                     (state == ST_AD0) ? ST_AD1 : ST_AD2;
                    end
                end
                ST_AD2: begin
                    if (!phase) begin
                        phase    <= 1'b1;
                        onfi_wen <= 1'b1;
                    end else begin
                        phase      <= 1'b0;
                        onfi_ale   <= 1'b0;
                        onfi_dq_en <= 1'b0;
                        onfi_dq_o  <= '0;
                        cnt        <= '0;
                        state      <= ST_WHR;
                    end
                end
                ST_WHR: begin
                    if (cnt == CW'(WHR_CYC - 1)) begin
                        cnt         <= '0;
                        onfi_dqs_en <= 1'b1;
                        state       <= ST_READ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_READ: begin
                    // DQ is stable while DQS is high, so sample it in the edge cycle.
                    if (dqs_rise) begin
                        data  <= pack_result(1'b0, 1'b1, onfi_dq);
                        state <= ST_CAP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        data  <= pack_result(1'b1, 1'b0, 8'h00);
                        state <= ST_TOUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_CAP, ST_TOUT: begin
                    onfi_cen    <= 1'b1;
                    onfi_dqs_en <= 1'b0;
                    cnt         <= '0;
                    state       <= ST_GAP;
                end
                ST_GAP: begin
                    if (cnt == CW'(GAP_CYC - 1)) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_onfi_get_status.sv
// Directed bench for onfi_get_status: command framing, timeout, capture, held-high DQS, reset abort.
module tb_onfi_get_status;

    logic        onfi_clk;
    logic        rst;
    logic [31:0] addr;
    logic [7:0]  onfi_dq;
    logic        onfi_dqs;
    logic [31:0] data;
    logic        onfi_cen;
    logic        onfi_cle;
    logic        onfi_ale;
    logic        onfi_wen;
    logic [31:0] onfi_dq_o;
    logic        onfi_dq_en;
    logic        onfi_dqs_en;

    int vectors;
    int miscompares;

    onfi_get_status #(.T_WHR(6), .TIMEOUT(64), .GAP(4)) dut (
        .onfi_clk    (onfi_clk),
        .rst         (rst),
        .addr        (addr),
        .onfi_dq     (onfi_dq),
        .onfi_dqs    (onfi_dqs),
        .data        (data),
        .onfi_cen    (onfi_cen),
        .onfi_cle    (onfi_cle),
        .onfi_ale    (onfi_ale),
        .onfi_wen    (onfi_wen),
        .onfi_dq_o   (onfi_dq_o),
        .onfi_dq_en  (onfi_dq_en),
        .onfi_dqs_en (onfi_dqs_en)
    );

    initial begin
        onfi_clk = 1'b0;
        forever #5 onfi_clk = ~onfi_clk;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge onfi_clk);
            @(negedge onfi_clk);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        addr        = 32'h0012_3456;
        onfi_dq     = 8'h00;
        onfi_dqs    = 1'b0;

        step(3);
        chk("rst_cen",    {31'h0, onfi_cen},    32'd1);
        chk("rst_wen",    {31'h0, onfi_wen},    32'd1);
        chk("rst_cle",    {31'h0, onfi_cle},    32'd0);
        chk("rst_ale",    {31'h0, onfi_ale},    32'd0);
        chk("rst_dq_en",  {31'h0, onfi_dq_en},  32'd0);
        chk("rst_dqs_en", {31'h0, onfi_dqs_en}, 32'd0);
        chk("rst_dq_o",   onfi_dq_o,            32'h0);
        chk("rst_data",   data,                 32'h0);

        // Transaction 1: timeout path
        rst = 1'b0;
        step(1);
        chk("cmd0_cen",   {31'h0, onfi_cen},   32'd0);
        chk("cmd0_cle",   {31'h0, onfi_cle},   32'd1);
        chk("cmd0_ale",   {31'h0, onfi_ale},   32'd0);
        chk("cmd0_wen",   {31'h0, onfi_wen},   32'd0);
        chk("cmd0_dq_en", {31'h0, onfi_dq_en}, 32'd1);
        chk("cmd0_dq_o",  onfi_dq_o,           32'h78);
        step(1);
        chk("cmd1_cle",   {31'h0, onfi_cle},   32'd1);
        chk("cmd1_wen",   {31'h0, onfi_wen},   32'd1);
        chk("cmd1_dq_o",  onfi_dq_o,           32'h78);
        addr = 32'hFFAA_BBCC;
        step(1);
        chk("ad0p0_ale",  {31'h0, onfi_ale},   32'd1);
        chk("ad0p0_cle",  {31'h0, onfi_cle},   32'd0);
        chk("ad0p0_wen",  {31'h0, onfi_wen},   32'd0);
        chk("ad0p0_dq_o", onfi_dq_o,           32'h56);
        chk("ad0p0_dqen", {31'h0, onfi_dq_en}, 32'd1);
        step(1);
        chk("ad0p1_ale",  {31'h0, onfi_ale},   32'd1);
        chk("ad0p1_wen",  {31'h0, onfi_wen},   32'd1);
        chk("ad0p1_dq_o", onfi_dq_o,           32'h56);
        step(1);
        chk("ad1p0_ale",  {31'h0, onfi_ale},   32'd1);
        chk("ad1p0_wen",  {31'h0, onfi_wen},   32'd0);
        chk("ad1p0_dq_o", onfi_dq_o,           32'h34);
        step(1);
        chk("ad1p1_ale",  {31'h0, onfi_ale},   32'd1);
        chk("ad1p1_wen",  {31'h0, onfi_wen},   32'd1);
        step(1);
        chk("ad2p0_ale",  {31'h0, onfi_ale},   32'd1);
        chk("ad2p0_wen",  {31'h0, onfi_wen},   32'd0);
        chk("ad2p0_dq_o", onfi_dq_o,           32'h12);
        step(1);
        chk("ad2p1_ale",  {31'h0, onfi_ale},   32'd1);
        chk("ad2p1_wen",  {31'h0, onfi_wen},   32'd1);
        chk("ad2p1_dq_o", onfi_dq_o,           32'h12);
        step(1);
        chk("whr_ale",    {31'h0, onfi_ale},    32'd0);
        chk("whr_cle",    {31'h0, onfi_cle},    32'd0);
        chk("whr_dq_en",  {31'h0, onfi_dq_en},  32'd0);
        chk("whr_dqs_en", {31'h0, onfi_dqs_en}, 32'd0);
        chk("whr_cen",    {31'h0, onfi_cen},    32'd0);
        step(5);
        chk("whr_last_dqs_en", {31'h0, onfi_dqs_en}, 32'd0);
        step(1);
        chk("read_entry_dqs_en", {31'h0, onfi_dqs_en}, 32'd1);
        step(63);
        chk("read_last_data",   data,                  32'h0);
        chk("read_last_dqs_en", {31'h0, onfi_dqs_en},  32'd1);
        step(1);
        chk("tout_data", data,                32'h0000_0200);
        chk("tout_cen",  {31'h0, onfi_cen},   32'd0);
        step(1);
        chk("gap_cen",    {31'h0, onfi_cen},    32'd1);
        chk("gap_dqs_en", {31'h0, onfi_dqs_en}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("gap_cen_hold", {31'h0, onfi_cen}, 32'd1);
        end

        // Transaction 2: back-to-back, addr latched in the IDLE cycle just passed
        step(1);
        chk("t2_cen_low",  {31'h0, onfi_cen}, 32'd0);
        chk("t2_cle",      {31'h0, onfi_cle}, 32'd1);
        chk("t2_data_cmd", data,              32'h0000_0200);
        step(2);
        chk("t2_ad0",      onfi_dq_o, 32'hCC);
        chk("t2_data_ad0", data,      32'h0000_0200);
        step(2);
        chk("t2_ad1",      onfi_dq_o, 32'hBB);
        chk("t2_data_ad1", data,      32'h0000_0200);
        step(2);
        chk("t2_ad2",      onfi_dq_o, 32'hAA);
        chk("t2_data_ad2", data,      32'h0000_0200);
        step(1);
        onfi_dq = 8'hE0;
        step(9);
        onfi_dqs = 1'b1;
        step(2);
        chk("cap_not_early", data, 32'h0000_0200);
        step(1);
        chk("cap_data",   data,                 32'h0000_01E0);
        chk("cap_dqs_en", {31'h0, onfi_dqs_en}, 32'd1);
        step(1);
        chk("cap_dqs_en_drop", {31'h0, onfi_dqs_en}, 32'd0);
        chk("cap_gap_cen",     {31'h0, onfi_cen},    32'd1);
        step(6);
        onfi_dqs = 1'b0;

        // Transaction 3: DQS already high before READ, never toggles
        step(5);
        onfi_dqs = 1'b1;
        onfi_dq  = 8'h5A;
        step(7);
        chk("t3_read_dqs_en", {31'h0, onfi_dqs_en}, 32'd1);
        step(63);
        chk("t3_no_capture", data, 32'h0000_01E0);
        step(1);
        chk("t3_timeout", data, 32'h0000_0200);
        step(4);
        chk("t3_idle_cen", {31'h0, onfi_cen}, 32'd1);
        step(1);
        chk("t4_cen_low", {31'h0, onfi_cen}, 32'd0);
        onfi_dqs = 1'b0;

        // Transaction 4: reset in the middle of AD1
        step(4);
        chk("t4_ad1_ale",  {31'h0, onfi_ale}, 32'd1);
        chk("t4_ad1_dq_o", onfi_dq_o,         32'hBB);
        rst = 1'b1;
        step(1);
        chk("abort_cen",   {31'h0, onfi_cen},   32'd1);
        chk("abort_ale",   {31'h0, onfi_ale},   32'd0);
        chk("abort_wen",   {31'h0, onfi_wen},   32'd1);
        chk("abort_dq_en", {31'h0, onfi_dq_en}, 32'd0);
        chk("abort_dq_o",  onfi_dq_o,           32'h0);
        chk("abort_data",  data,                32'h0);
        rst  = 1'b0;
        addr = 32'h00AB_CDEF;
        step(1);
        chk("restart_cen",  {31'h0, onfi_cen}, 32'd0);
        chk("restart_cle",  {31'h0, onfi_cle}, 32'd1);
        chk("restart_dq_o", onfi_dq_o,         32'h78);
        step(2);
        chk("restart_ad0", onfi_dq_o, 32'hEF);
        step(2);
        chk("restart_ad1", onfi_dq_o, 32'hCD);
        step(2);
        chk("restart_ad2",     onfi_dq_o,         32'hAB);
        chk("restart_ad2_ale", {31'h0, onfi_ale}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
